// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, opcode encodings and the
// command sequencer FSM state encoding.
package alu_pkg;

   localparam int WIDTH = 32;

   localparam logic [2:0] OP_ADD     = 3'b000;
   localparam logic [2:0] OP_SHL     = 3'b001;
   localparam logic [2:0] OP_TRUNC   = 3'b010;
   localparam logic [2:0] OP_AND     = 3'b011;
   localparam logic [2:0] OP_OR      = 3'b100;
   localparam logic [2:0] OP_NOT     = 3'b101;
   localparam logic [2:0] OP_XOR     = 3'b110;
   localparam logic [2:0] OP_ILLEGAL = 3'b111;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU driven by alu_cmd_sequencer.
// Ports: x, y operands; op opcode; f result (same cycle).
module alu
   import alu_pkg::*;
(
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] f
);

   always_comb begin
      f = '0;
      case (op)
         OP_ADD:   f = x + y;
         OP_SHL:   f = x << y[4:0];
         OP_TRUNC: f = {16'h0000, x[15:0]};
         OP_AND:   f = x & y;
         OP_OR:    f = x | y;
         OP_NOT:   f = ~x;
         OP_XOR:   f = x ^ y;
         default:  f = '0;
      endcase
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator for the combinational ALU: accepts one command at a time,
// drives registered x/y/op, samples f one cycle later and returns it.
// Ports: clk, rst (sync, active-high); cmd_* valid/ready command input;
// alu_x/alu_y/alu_op to the ALU, alu_f back; res_* valid/ready result;
// op_count counts result handshakes (wraps).
// Optional: define ALU_CHAIN_EN to let cmd_chain feed the last legal
// result back as the x operand.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int OP_W  = 3,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [OP_W-1:0]  cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic             cmd_chain,
   output logic [WIDTH-1:0] alu_x,
   output logic [WIDTH-1:0] alu_y,
   output logic [OP_W-1:0]  alu_op,
   input  logic [WIDTH-1:0] alu_f,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic [OP_W-1:0]  res_op,
   output logic             res_err,
   output logic [CNT_W-1:0] op_count
);

   localparam logic [OP_W-1:0] ILL = OP_W'(OP_ILLEGAL);

   logic [1:0]       state;
   logic [WIDTH-1:0] x_next;

   assign cmd_ready = (state == ST_IDLE);
   assign res_valid = (state == ST_HOLD);

`ifdef ALU_CHAIN_EN
   logic [WIDTH-1:0] chain_q;

   assign x_next = cmd_chain ? chain_q : cmd_a;

   // Only legal results are remembered for chaining.
   always_ff @(posedge clk) begin
      if (rst)
         chain_q <= '0;
      else if (res_valid && res_ready && !res_err)
         chain_q <= res_data;
   end
`else
   logic unused_chain;

   assign unused_chain = cmd_chain;
   assign x_next       = cmd_a;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         alu_x    <= '0;
         alu_y    <= '0;
         alu_op   <= '0;
         res_data <= '0;
         res_op   <= '0;
         res_err  <= 1'b0;
         op_count <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  if (cmd_op == ILL) begin
                     // Illegal ops skip the ALU; its drive is left alone.
                     res_data <= '0;
                     res_op   <= cmd_op;
                     res_err  <= 1'b1;
                     state    <= ST_HOLD;
                  end else begin
                     alu_x  <= x_next;
                     alu_y  <= cmd_b;
                     alu_op <= cmd_op;
                     state  <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               // Registered drive has settled for one cycle by now.
               res_data <= alu_f;
               res_op   <= alu_op;
               res_err  <= 1'b0;
               state    <= ST_HOLD;
            end
            ST_HOLD: begin
               if (res_ready) begin
                  op_count <= op_count + 1'b1;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a real alu
// wired on its ALU port; op_count is narrowed to 4 bits to reach wrap.
module tb_alu_cmd_sequencer;
   import alu_pkg::*;

`ifdef ALU_CHAIN_EN
   localparam logic [31:0] CHAIN_EXP = 32'd17;
`else
   localparam logic [31:0] CHAIN_EXP = 32'd109;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [31:0] cmd_a;
   logic [31:0] cmd_b;
   logic        cmd_chain;
   logic [31:0] alu_x;
   logic [31:0] alu_y;
   logic [2:0]  alu_op;
   logic [31:0] alu_f;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic [2:0]  res_op;
   logic        res_err;
   logic [3:0]  op_count;

   int total  = 0;
   int passes = 0;

   always #5 clk = ~clk;

   alu_cmd_sequencer #(
      .WIDTH(32),
      .OP_W (3),
      .CNT_W(4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op   (cmd_op),
      .cmd_a    (cmd_a),
      .cmd_b    (cmd_b),
      .cmd_chain(cmd_chain),
      .alu_x    (alu_x),
      .alu_y    (alu_y),
      .alu_op   (alu_op),
      .alu_f    (alu_f),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_data (res_data),
      .res_op   (res_op),
      .res_err  (res_err),
      .op_count (op_count)
   );

   alu u_alu (
      .x (alu_x),
      .y (alu_y),
      .op(alu_op),
      .f (alu_f)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Starts and ends on a falling edge; full transaction, res_ready=1.
   task automatic run_cmd(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic ch,
                          output logic [31:0] data);
      int n;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      cmd_chain = ch;
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_chain = 1'b0;
      n = 0;
      while (res_valid !== 1'b1 && n < 6) begin
         @(negedge clk);
         n++;
      end
      chk("run_valid", {31'd0, res_valid}, 32'd1);
      data = res_data;
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] d;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_a     = '0;
      cmd_b     = '0;
      cmd_chain = 1'b0;
      res_ready = 1'b0;
      repeat (2) @(negedge clk);

      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_res_err", {31'd0, res_err}, 32'd0);
      chk("rst_alu_x", alu_x, 32'd0);
      chk("rst_res_data", res_data, 32'd0);
      chk("rst_op_count", {28'd0, op_count}, 32'd0);

      // add 5+7, res_ready already high
      rst       = 1'b0;
      res_ready = 1'b1;
      cmd_valid = 1'b1;
      cmd_op    = OP_ADD;
      cmd_a     = 32'd5;
      cmd_b     = 32'd7;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("add_issue_valid", {31'd0, res_valid}, 32'd0);
      chk("add_issue_ready", {31'd0, cmd_ready}, 32'd0);
      chk("add_alu_x", alu_x, 32'd5);
      @(negedge clk);
      chk("add_hold_valid", {31'd0, res_valid}, 32'd1);
      chk("add_data", res_data, 32'd12);
      chk("add_op", {29'd0, res_op}, 32'd0);
      chk("add_err", {31'd0, res_err}, 32'd0);
      @(negedge clk);
      chk("add_count", {28'd0, op_count}, 32'd1);
      chk("add_done_valid", {31'd0, res_valid}, 32'd0);
      chk("add_done_ready", {31'd0, cmd_ready}, 32'd1);

      // and with backpressure
      res_ready = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = OP_AND;
      cmd_a     = 32'hFF00FF00;
      cmd_b     = 32'h0FF00FF0;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("and_hold_valid", {31'd0, res_valid}, 32'd1);
         chk("and_hold_data", res_data, 32'h0F000F00);
         chk("and_hold_ready", {31'd0, cmd_ready}, 32'd0);
         @(negedge clk);
      end
      res_ready = 1'b1;
      @(negedge clk);
      chk("and_count", {28'd0, op_count}, 32'd2);
      chk("and_ready_back", {31'd0, cmd_ready}, 32'd1);

      // illegal op: one-cycle turnaround, ALU drive untouched
      res_ready = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = OP_ILLEGAL;
      cmd_a     = 32'd1;
      cmd_b     = 32'd2;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("ill_valid", {31'd0, res_valid}, 32'd1);
      chk("ill_err", {31'd0, res_err}, 32'd1);
      chk("ill_data", res_data, 32'd0);
      chk("ill_op", {29'd0, res_op}, 32'd7);
      chk("ill_alu_x", alu_x, 32'hFF00FF00);
      chk("ill_alu_y", alu_y, 32'h0FF00FF0);
      chk("ill_alu_op", {29'd0, alu_op}, 32'd3);
      res_ready = 1'b1;
      @(negedge clk);
      chk("ill_count", {28'd0, op_count}, 32'd3);

      // reset while in ISSUE aborts the command
      cmd_valid = 1'b1;
      cmd_op    = OP_OR;
      cmd_a     = 32'h000000F0;
      cmd_b     = 32'h0000000F;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      rst       = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_valid", {31'd0, res_valid}, 32'd0);
      chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
      chk("abort_alu_x", alu_x, 32'd0);
      chk("abort_data", res_data, 32'd0);
      chk("abort_count", {28'd0, op_count}, 32'd0);
      @(negedge clk);
      chk("abort_no_res", {31'd0, res_valid}, 32'd0);
      run_cmd(OP_OR, 32'h000000F0, 32'h0000000F, 1'b0, d);
      chk("or_after_abort", d, 32'h000000FF);

      // chaining
      run_cmd(OP_ADD, 32'd3, 32'd4, 1'b0, d);
      chk("chain_first", d, 32'd7);
      run_cmd(OP_ADD, 32'd99, 32'd10, 1'b1, d);
      chk("chain_second", d, CHAIN_EXP);
      chk("chain_count", {28'd0, op_count}, 32'd3);

      // counter wrap (4-bit)
      for (int i = 0; i < 12; i++)
         run_cmd(OP_ILLEGAL, 32'd0, 32'd0, 1'b0, d);
      chk("count_max", {28'd0, op_count}, 32'd15);
      run_cmd(OP_XOR, 32'h0000FFFF, 32'h00FF00FF, 1'b0, d);
      chk("xor_data", d, 32'h00FFFF00);
      chk("count_wrap", {28'd0, op_count}, 32'd0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
